issue_rat_fgr_ctrl: RTL and testbench

ISSUE_RAT_FGR_CTRL -- requirements
Module: issue_rat_fgr_ctrl

---
 rtl/issue_rat_fgr_ctrl.sv | 76 +++++++
 tb/tb_issue_rat_fgr_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/issue_rat_fgr_ctrl.sv
// issue_rat_fgr_ctrl: speculative group (FGR) allocator with in-order commit and youngest-first abandon walk
module issue_rat_fgr_ctrl #(
  parameter int FGR_N = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_alloc_valid,
  output logic       o_alloc_ready,
  output logic [3:0] o_alloc_fgr,
  output logic [3:0] o_cur_fgr,
  output logic       o_cur_speculative,
  input  logic       i_commit_valid,
  output logic       o_commit_ready,
  input  logic       i_flush_valid,
  input  logic [3:0] i_flush_fgr,
  output logic [3:0] o_commit_fgr,
  output logic       o_commit_valid,
  output logic [3:0] o_abandon_fgr,
  output logic       o_abandon_valid,
  output logic       o_busy
);
  typedef enum logic {IDLE, ABANDON} state_t;
  state_t     state_q, state_d;
  logic [4:0] head_q, head_d, tail_q, tail_d, target_q, target_d;
  logic [4:0] count, count_c, tail_m1, head_c;
  logic [3:0] offset, commit_fgr_q, commit_fgr_d;
  logic       commit_valid_q, commit_valid_d;
  logic       idle, alloc_fire, commit_fire, flush_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      target_q       <= '0;
      commit_fgr_q   <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      target_q       <= target_d;
      commit_fgr_q   <= commit_fgr_d;
      commit_valid_q <= commit_valid_d;
    end
  end
  // flush window is checked against the head as it will be after a same-cycle commit
  always_comb begin
    alloc_fire     = i_alloc_valid && o_alloc_ready;
    commit_fire    = i_commit_valid && o_commit_ready;
    head_c         = head_q + {4'd0, commit_fire};
    count_c        = tail_q - head_c;
    offset         = i_flush_fgr - head_c[3:0];
    flush_ok       = idle && i_flush_valid && ({1'b0, offset} < count_c);
    state_d        = idle ? (flush_ok ? ABANDON : IDLE) : (tail_m1 == target_q ? IDLE : ABANDON);
    head_d         = head_c;
    tail_d         = idle ? tail_q + {4'd0, alloc_fire} : tail_m1;
    target_d       = flush_ok ? head_c + {1'b0, offset} : target_q;
    commit_fgr_d   = head_q[3:0];
    commit_valid_d = commit_fire;
  end
  always_comb begin
    idle              = state_q == IDLE;
    count             = tail_q - head_q;
    tail_m1           = tail_q - 5'd1;
    o_alloc_ready     = idle && (count < 5'(FGR_N)) && !i_flush_valid;
    o_commit_ready    = idle && (count != 5'd0);
    o_alloc_fgr       = tail_q[3:0];
    o_cur_fgr         = tail_m1[3:0];
    o_cur_speculative = count != 5'd0;
    o_commit_fgr      = commit_fgr_q;
    o_commit_valid    = commit_valid_q;
    o_abandon_fgr     = tail_m1[3:0];
    o_abandon_valid   = !idle;
    o_busy            = !idle;
  end
endmodule

// File: tb/tb_issue_rat_fgr_ctrl.sv
// tb_issue_rat_fgr_ctrl: directed checks of allocation, commit, flush/abandon and reset behaviour
module tb_issue_rat_fgr_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_alloc_valid, i_commit_valid, i_flush_valid;
  logic [3:0] i_flush_fgr;
  logic       o_alloc_ready, o_cur_speculative, o_commit_ready, o_commit_valid, o_abandon_valid, o_busy;
  logic [3:0] o_alloc_fgr, o_cur_fgr, o_commit_fgr, o_abandon_fgr;
  int errors = 0;
  int checks = 0;
  issue_rat_fgr_ctrl #(.FGR_N(16)) dut (
    .clk(clk), .reset(reset),
    .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready), .o_alloc_fgr(o_alloc_fgr),
    .o_cur_fgr(o_cur_fgr), .o_cur_speculative(o_cur_speculative),
    .i_commit_valid(i_commit_valid), .o_commit_ready(o_commit_ready),
    .i_flush_valid(i_flush_valid), .i_flush_fgr(i_flush_fgr),
    .o_commit_fgr(o_commit_fgr), .o_commit_valid(o_commit_valid),
    .o_abandon_fgr(o_abandon_fgr), .o_abandon_valid(o_abandon_valid), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic a, input logic c, input logic f, input logic [3:0] fg);
    i_alloc_valid = a; i_commit_valid = c; i_flush_valid = f; i_flush_fgr = fg;
    #1;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask
  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    do_reset();
    chk("rst_alloc_ready", 8'(o_alloc_ready), 8'd1);
    chk("rst_alloc_fgr", 8'(o_alloc_fgr), 8'd0);
    chk("rst_cur_fgr", 8'(o_cur_fgr), 8'd15);
    chk("rst_spec", 8'(o_cur_speculative), 8'd0);
    chk("rst_busy", 8'(o_busy), 8'd0);
    chk("rst_commit_valid", 8'(o_commit_valid), 8'd0);
    chk("rst_abandon_valid", 8'(o_abandon_valid), 8'd0);
    chk("rst_commit_ready", 8'(o_commit_ready), 8'd0);
    // commit with nothing outstanding is ignored
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("empty_commit_pulse", 8'(o_commit_valid), 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      chk($sformatf("alloc_fgr_%0d", i), 8'(o_alloc_fgr), 8'(i));
      tick();
    end
    drive(0, 0, 0, 0);
    chk("cur_fgr_after3", 8'(o_cur_fgr), 8'd2);
    chk("spec_after3", 8'(o_cur_speculative), 8'd1);
    drive(1, 0, 0, 0);
    tick();
    // out-of-window flush (groups 0..3) is ignored and blocks allocation that cycle
    drive(1, 0, 1, 7);
    chk("flush_blocks_alloc", 8'(o_alloc_ready), 8'd0);
    tick();
    drive(0, 0, 0, 0);
    chk("bad_flush_busy", 8'(o_busy), 8'd0);
    chk("bad_flush_abandon", 8'(o_abandon_valid), 8'd0);
    chk("bad_flush_cur", 8'(o_cur_fgr), 8'd3);
    drive(1, 0, 0, 0);
    tick();
    // groups 0..4: flush 2 -> abandon 4,3,2
    drive(0, 0, 1, 2);
    tick();
    drive(0, 0, 0, 0);
    chk("ab1_valid", 8'(o_abandon_valid), 8'd1);
    chk("ab1_fgr", 8'(o_abandon_fgr), 8'd4);
    chk("ab1_busy", 8'(o_busy), 8'd1);
    chk("ab1_commit_ready", 8'(o_commit_ready), 8'd0);
    chk("ab1_alloc_ready", 8'(o_alloc_ready), 8'd0);
    tick();
    drive(0, 1, 1, 0);
    chk("ab2_fgr", 8'(o_abandon_fgr), 8'd3);
    chk("ab2_busy", 8'(o_busy), 8'd1);
    tick();
    drive(0, 0, 0, 0);
    chk("ab3_fgr", 8'(o_abandon_fgr), 8'd2);
    chk("ab3_valid", 8'(o_abandon_valid), 8'd1);
    chk("ab_ignored_commit", 8'(o_commit_valid), 8'd0);
    tick();
    chk("ab_done_busy", 8'(o_busy), 8'd0);
    chk("ab_done_valid", 8'(o_abandon_valid), 8'd0);
    chk("ab_done_cur", 8'(o_cur_fgr), 8'd1);
    // head 0 tail 2 -> commit twice
    drive(0, 1, 0, 0);
    chk("commit_ready", 8'(o_commit_ready), 8'd1);
    tick();
    chk("commit0_valid", 8'(o_commit_valid), 8'd1);
    chk("commit0_fgr", 8'(o_commit_fgr), 8'd0);
    tick();
    drive(0, 0, 0, 0);
    chk("commit1_fgr", 8'(o_commit_fgr), 8'd1);
    chk("spec_empty", 8'(o_cur_speculative), 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    // head 2 tail 5: commit + flush 2 same cycle -> commit wins
    drive(0, 1, 1, 2);
    tick();
    drive(0, 0, 0, 0);
    chk("cf_commit_valid", 8'(o_commit_valid), 8'd1);
    chk("cf_commit_fgr", 8'(o_commit_fgr), 8'd2);
    chk("cf_abandon", 8'(o_abandon_valid), 8'd0);
    tick();
    chk("cf_pulse_end", 8'(o_commit_valid), 8'd0);
    chk("cf_no_abandon", 8'(o_abandon_valid), 8'd0);
    chk("cf_cur", 8'(o_cur_fgr), 8'd4);
    // alloc + commit together: head 3 tail 5 -> head 4 tail 6
    drive(1, 1, 0, 0);
    chk("ac_alloc_fgr", 8'(o_alloc_fgr), 8'd5);
    tick();
    drive(0, 0, 0, 0);
    chk("ac_commit_fgr", 8'(o_commit_fgr), 8'd3);
    chk("ac_cur", 8'(o_cur_fgr), 8'd5);
    chk("ac_spec", 8'(o_cur_speculative), 8'd1);
    // fill to 16
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    chk("full_ready", 8'(o_alloc_ready), 8'd0);
    tick();
    chk("full_cur", 8'(o_cur_fgr), 8'd15);
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("full_commit_fgr", 8'(o_commit_fgr), 8'd0);
    chk("full_ready_back", 8'(o_alloc_ready), 8'd1);
    // head 1 tail 16 -> head 14, then tail 18
    for (int i = 0; i < 13; i++) begin
      drive(0, 1, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0);
    chk("wrap_alloc_fgr0", 8'(o_alloc_fgr), 8'd0);
    tick();
    tick();
    drive(0, 0, 0, 0);
    chk("wrap_cur", 8'(o_cur_fgr), 8'd1);
    drive(0, 0, 1, 15);
    tick();
    drive(0, 0, 0, 0);
    chk("wrap_ab1", 8'(o_abandon_fgr), 8'd1);
    tick();
    chk("wrap_ab2", 8'(o_abandon_fgr), 8'd0);
    tick();
    chk("wrap_ab3", 8'(o_abandon_fgr), 8'd15);
    chk("wrap_ab3_valid", 8'(o_abandon_valid), 8'd1);
    tick();
    chk("wrap_done", 8'(o_abandon_valid), 8'd0);
    chk("wrap_cur_after", 8'(o_cur_fgr), 8'd14);
    // reset mid-walk
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("mid_ab_valid", 8'(o_abandon_valid), 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_abandon", 8'(o_abandon_valid), 8'd0);
    chk("mid_rst_busy", 8'(o_busy), 8'd0);
    chk("mid_rst_cur", 8'(o_cur_fgr), 8'd15);
    tick();
    chk("mid_rst_abandon2", 8'(o_abandon_valid), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
